// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline definitions: controller FSM encodings and default limits.
// The pipeline-register modules and the bench use the same names.
package pipeline_stall_ctrl_pkg;

  // Controller states. Encoding 3 is never entered; the FSM falls back to RUN from it.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } ctrl_state_t;

  // Default limit on consecutive memory-wait cycles before a fatal halt.
  localparam int unsigned DEFAULT_MEM_TIMEOUT = 255;

  // Default width of the performance counters.
  localparam int unsigned DEFAULT_CNT_W = 16;

  // Width of the memory-wait counter, wide enough for the largest legal timeout (65535).
  localparam int unsigned WAIT_CNT_W = 16;

endpackage : pipeline_stall_ctrl_pkg

// File: rtl/pipeline_stall_ctrl_hazard_cmp.sv
// Register hazard comparator: flags a match when the destination of the
// in-flight load equals any source register of the bundle in ID.
// The fourth source counts only when the store flag marks it as a source.
module hazard_cmp (
  input  logic [2:0] dest_i,
  input  logic [2:0] src_a_i,
  input  logic [2:0] src_b_i,
  input  logic [2:0] src_c_i,
  input  logic [2:0] src_d_i,
  input  logic       src_d_valid_i,
  output logic       match_o
);

  assign match_o = (dest_i == src_a_i) ||
                   (dest_i == src_b_i) ||
                   (dest_i == src_c_i) ||
                   (src_d_valid_i && (dest_i == src_d_i));

endmodule : hazard_cmp

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller. It resolves, in priority order, halt,
// memory wait, branch/jump redirect and load-use hazards. It drives
// combinational per-stage stall and flush controls, and keeps a small FSM
// with sticky status and saturating performance counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       id_alu_rn,
  input  logic [2:0]       id_alu_rm,
  input  logic [2:0]       id_mem_rn,
  input  logic [2:0]       id_mem_rd,
  input  logic             id_mem_isStore,
  input  logic             ex_memRead,
  input  logic [2:0]       ex_mem_rd,
  input  logic             ex_branchTaken,
  input  logic             ex_isJump,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             undef_instr,
  output logic             global_regWrite,
  output logic             IF_flush,
  output logic             ID_flush,
  output logic             EX_flush,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             wb_stall,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  localparam logic [WAIT_CNT_W:0] TIMEOUT_LIM = (WAIT_CNT_W+1)'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

  ctrl_state_t           state_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic                  halted_q;
  logic                  timeout_q;
  logic [CNT_W-1:0]      stall_cnt_q;
  logic [CNT_W-1:0]      flush_cnt_q;

  logic                  hazard_match;
  logic                  in_halt;
  logic                  mem_wait;
  logic                  redirect;
  logic                  load_use;
  logic                  any_stall;
  logic [WAIT_CNT_W:0]   wait_cnt_d;

  hazard_cmp u_hazard_cmp (
    .dest_i        (ex_mem_rd),
    .src_a_i       (id_alu_rn),
    .src_b_i       (id_alu_rm),
    .src_c_i       (id_mem_rn),
    .src_d_i       (id_mem_rd),
    .src_d_valid_i (id_mem_isStore),
    .match_o       (hazard_match)
  );

  // Hazard resolution and per-stage controls, in priority order: halt > wait > redirect > load-use.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    global_regWrite = 1'b1;
    IF_flush        = 1'b0;
    ID_flush        = 1'b0;
    EX_flush        = 1'b0;
    if_stall        = 1'b0;
    id_stall        = 1'b0;
    ex_stall        = 1'b0;
    mem_stall       = 1'b0;
    wb_stall        = 1'b0;

    in_halt  = (state_q == ST_HALT);
    mem_wait = !in_halt && mem_req && !mem_ready;
    redirect = !in_halt && !mem_wait && (ex_branchTaken || ex_isJump);
    load_use = (state_q == ST_RUN) && !mem_wait && !redirect && ex_memRead && hazard_match;

    if (in_halt) begin
      global_regWrite = 1'b0;
      if_stall        = 1'b1;
      id_stall        = 1'b1;
      ex_stall        = 1'b1;
      mem_stall       = 1'b1;
      wb_stall        = 1'b1;
    end else if (mem_wait) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
    end else if (redirect) begin
      IF_flush = 1'b1;
      ID_flush = 1'b1;
    end else if (load_use) begin
      if_stall = 1'b1;
      id_stall = 1'b1;
    end

    any_stall = mem_wait || load_use;

    // The first wait cycle seen from RUN counts as 1; later cycles in MEM_WAIT add one each.
    wait_cnt_d = (state_q == ST_MEM_WAIT) ? ({1'b0, wait_cnt_q} + (WAIT_CNT_W+1)'(1))
                                          : (WAIT_CNT_W+1)'(1);
  end

  // FSM, memory-wait counter, sticky status flags and saturating performance counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (any_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (redirect && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end

      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (undef_instr) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (mem_wait) begin
            if (wait_cnt_d >= TIMEOUT_LIM) begin
              state_q   <= ST_HALT;
              halted_q  <= 1'b1;
              timeout_q <= 1'b1;
            end else begin
              state_q    <= ST_MEM_WAIT;
              wait_cnt_q <= wait_cnt_d[WAIT_CNT_W-1:0];
            end
          end else begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q    <= ST_RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign halted      = halted_q;
  assign timeout_err = timeout_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
  assign state       = state_q;

endmodule : pipeline_stall_ctrl

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum consecutive memory-wait cycles before a fatal halt; legal range 1..65535.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd  in  3 each  source register fields of the bundle in ID.
REQ-006 id_mem_isStore  in  1  the ID memory slot is a store, so id_mem_rd is a source.
REQ-007 ex_memRead  in  1  the EX memory slot is a load; ex_mem_rd  in  3  its destination.
REQ-008 ex_branchTaken, ex_isJump  in  1 each  EX resolves a redirect.
REQ-009 mem_req  in  1  MEM stage access active; mem_ready  in  1  data memory completes the access this cycle.
REQ-010 undef_instr  in  1  ID decoded an undefined instruction in either slot.
REQ-011 global_regWrite  out  1  global pipeline-register enable.
REQ-012 IF_flush, ID_flush, EX_flush  out  1 each  per-stage flushes.
REQ-013 if_stall, id_stall, ex_stall, mem_stall, wb_stall  out  1 each  per-stage holds.
REQ-014 halted, timeout_err  out  1 each  sticky status.
REQ-015 stall_count, flush_count  out  CNT_W each  saturating performance counters.
REQ-016 state  out  2  current FSM state, for debug.

Function
REQ-017 FSM states: RUN=0, MEM_WAIT=1, HALT=2; encoding 3 is unreachable and SHALL recover to RUN on the next edge.
REQ-018 Condition priority within a cycle: HALT > memory wait > redirect > load-use.
REQ-019 Load-use condition: in RUN, ex_memRead=1 and ex_mem_rd equals id_alu_rn, id_alu_rm, id_mem_rn, or (id_mem_rd when id_mem_isStore=1).
REQ-020 On load-use, the block SHALL assert if_stall=id_stall=1 combinationally for exactly one cycle, inserting one bubble; the bubble is cleared downstream by the pipeline.
REQ-021 Redirect condition: ex_branchTaken or ex_isJump, with no memory wait active.
REQ-022 On redirect, the block SHALL assert IF_flush=ID_flush=1 for exactly one cycle, with EX_flush=0 and no stall outputs asserted.
REQ-023 Redirect and load-use in the same cycle: the flush is applied; the stall is suppressed.
REQ-024 Memory-wait condition: mem_req=1 and mem_ready=0.
REQ-025 During a memory wait, if/id/ex/mem_stall SHALL be 1 combinationally in the same cycle, wb_stall=0, and no flushes are asserted.
REQ-026 Memory wait from RUN: the FSM moves RUN->MEM_WAIT and the wait counter loads 1.
REQ-027 In MEM_WAIT the wait counter increments each cycle.
REQ-028 In MEM_WAIT, mem_ready=1 moves MEM_WAIT->RUN; in that cycle stalls drop and any pending redirect flush is applied.
REQ-029 In MEM_WAIT, when the wait counter reaches MEM_TIMEOUT with mem_ready=0, the FSM moves to HALT and sets timeout_err.
REQ-030 undef_instr=1 in RUN or MEM_WAIT moves the FSM to HALT on the next edge.
REQ-031 In HALT: global_regWrite=0, all stalls=1, halted=1; only reset exits HALT.
REQ-032 global_regWrite=1 in RUN and MEM_WAIT.
REQ-033 stall_count SHALL increment each cycle in which any stall output is 1 outside HALT, saturating at all-ones.
REQ-034 flush_count SHALL increment once per redirect, saturating at all-ones.

Reset
REQ-035 On reset, the FSM returns to RUN and the wait counter clears.
REQ-036 On reset: stall_count=flush_count=0, halted=timeout_err=0, and all stall and flush outputs deassert.
REQ-037 On reset, global_regWrite=1 from the first post-reset cycle.
REQ-038 Reset mid-wait or in HALT SHALL take effect at the next edge; no pending flush survives reset.

Structure
REQ-039 FSM state encodings and the default MEM_TIMEOUT SHALL live in the shared pipeline package, for reuse by the pipeline-register modules and the bench.
REQ-040 The 3-bit hazard comparator SHALL be one sub-module, hazard_cmp (inputs: destination, four sources, store flag; output: match).
REQ-041 All outputs except the counters and status flags are combinational from state and inputs; no latches.

Verification
REQ-042 ex_memRead=1, ex_mem_rd=3, id_alu_rm=3 -> if_stall=id_stall=1 for 1 cycle, stall_count=1.
REQ-043 Same load-use with ex_branchTaken=1 -> IF_flush=ID_flush=1, no stall, flush_count=1.
REQ-044 mem_req=1 with mem_ready low for 4 cycles, then high -> state MEM_WAIT 4 cycles, then RUN; stall_count=4.
REQ-045 MEM_TIMEOUT=8, mem_ready held 0 -> HALT after 8 wait cycles; timeout_err=1, global_regWrite=0.
REQ-046 undef_instr pulse, then reset asserted 3 cycles later -> halted=1 until reset; after reset state=RUN, counters=0.
REQ-047 CNT_W=4, 20 load-use events -> stall_count saturates at 15.
